// File: rtl/multicycle_control.sv
// Control FSM for a multi-cycle MIPS datapath with a shared, variable-latency memory.
// Strobes are decoded from the current state; FETCH, MEM_WR and BRANCH also depend on the inputs.
module multicycle_control #(
    parameter int WAIT_LIMIT = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_en,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_source,
    output logic       instr_done,
    output logic       trap
);

    localparam int CNT_W = ($clog2(WAIT_LIMIT + 1) < 4) ? 4 : $clog2(WAIT_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT   = CNT_W'(WAIT_LIMIT);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEM_ADDR = 4'd2;
    localparam logic [3:0] S_MEM_RD   = 4'd3;
    localparam logic [3:0] S_MEM_WB   = 4'd4;
    localparam logic [3:0] S_MEM_WR   = 4'd5;
    localparam logic [3:0] S_EXEC     = 4'd6;
    localparam logic [3:0] S_ALU_WB   = 4'd7;
    localparam logic [3:0] S_BRANCH   = 4'd8;
    localparam logic [3:0] S_JUMP     = 4'd9;
    localparam logic [3:0] S_ADDI_EX  = 4'd10;
    localparam logic [3:0] S_ADDI_WB  = 4'd11;
    localparam logic [3:0] S_TRAP     = 4'd12;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    logic [3:0]       state_q, state_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic             mem_state_s;

    logic       pc_en_s, i_or_d_s, mem_read_s, mem_write_s, ir_write_s;
    logic       reg_dst_s, mem_to_reg_s, reg_write_s, alu_src_a_s;
    logic [1:0] alu_src_b_s, alu_op_s, pc_source_s;
    logic       instr_done_s, trap_s;
    logic       run_s;

    assign mem_state_s = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);

    // Next-state logic and memory wait watchdog
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        case (state_q)
            S_FETCH:    state_d = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_RTYPE:      state_d = S_EXEC;
                    OP_LW, OP_SW:  state_d = S_MEM_ADDR;
                    OP_BEQ, OP_BNE: state_d = S_BRANCH;
                    OP_J:          state_d = S_JUMP;
                    OP_ADDI:       state_d = S_ADDI_EX;
                    default:       state_d = S_TRAP;
                endcase
            end
            S_MEM_ADDR: state_d = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:   state_d = mem_ready ? S_MEM_WB : S_MEM_RD;
            S_MEM_WB:   state_d = S_FETCH;
            S_MEM_WR:   state_d = mem_ready ? S_FETCH : S_MEM_WR;
            S_EXEC:     state_d = S_ALU_WB;
            S_ALU_WB:   state_d = S_FETCH;
            S_BRANCH:   state_d = S_FETCH;
            S_JUMP:     state_d = S_FETCH;
            S_ADDI_EX:  state_d = S_ADDI_WB;
            S_ADDI_WB:  state_d = S_FETCH;
            S_TRAP:     state_d = S_TRAP;
            default:    state_d = S_TRAP;
        endcase

        // A memory access that stalls past the limit is treated as a dead bus.
        if (!mem_state_s) begin
            wait_cnt_d = {CNT_W{1'b0}};
        end else if (mem_ready) begin
            wait_cnt_d = {CNT_W{1'b0}};
        end else if (wait_cnt_q == LIMIT) begin
            state_d    = S_TRAP;
            wait_cnt_d = {CNT_W{1'b0}};
        end else if (wait_cnt_q != CNT_MAX) begin
            wait_cnt_d = wait_cnt_q + CNT_ONE;
        end else begin
            wait_cnt_d = wait_cnt_q;
        end
    end

    // State and wait counter registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_FETCH;
            wait_cnt_q <= {CNT_W{1'b0}};
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // Per-state datapath controls
    always_comb begin
        pc_en_s      = 1'b0;
        i_or_d_s     = 1'b0;
        mem_read_s   = 1'b0;
        mem_write_s  = 1'b0;
        ir_write_s   = 1'b0;
        reg_dst_s    = 1'b0;
        mem_to_reg_s = 1'b0;
        reg_write_s  = 1'b0;
        alu_src_a_s  = 1'b0;
        alu_src_b_s  = 2'b00;
        alu_op_s     = 2'b00;
        pc_source_s  = 2'b00;
        instr_done_s = 1'b0;
        trap_s       = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_read_s  = 1'b1;
                alu_src_b_s = 2'b01;
                ir_write_s  = mem_ready;
                pc_en_s     = mem_ready;
            end
            S_DECODE:   alu_src_b_s = 2'b11;
            S_MEM_ADDR: begin
                alu_src_a_s = 1'b1;
                alu_src_b_s = 2'b10;
            end
            S_MEM_RD: begin
                mem_read_s = 1'b1;
                i_or_d_s   = 1'b1;
            end
            S_MEM_WB: begin
                reg_write_s  = 1'b1;
                mem_to_reg_s = 1'b1;
                instr_done_s = 1'b1;
            end
            S_MEM_WR: begin
                mem_write_s  = 1'b1;
                i_or_d_s     = 1'b1;
                instr_done_s = mem_ready;
            end
            S_EXEC: begin
                alu_src_a_s = 1'b1;
                alu_op_s    = 2'b10;
            end
            S_ALU_WB: begin
                reg_write_s  = 1'b1;
                reg_dst_s    = 1'b1;
                instr_done_s = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a_s  = 1'b1;
                alu_op_s     = 2'b01;
                pc_source_s  = 2'b01;
                pc_en_s      = opcode[0] ? ~zero : zero;
                instr_done_s = 1'b1;
            end
            S_JUMP: begin
                pc_source_s  = 2'b10;
                pc_en_s      = 1'b1;
                instr_done_s = 1'b1;
            end
            S_ADDI_EX: begin
                alu_src_a_s = 1'b1;
                alu_src_b_s = 2'b10;
            end
            S_ADDI_WB: begin
                reg_write_s  = 1'b1;
                instr_done_s = 1'b1;
            end
            S_TRAP:  trap_s = 1'b1;
            default: trap_s = 1'b0;
        endcase
    end

    // Reset aborts the current instruction immediately, so nothing may leak out during it.
    assign run_s      = ~reset;
    assign pc_en      = pc_en_s & run_s;
    assign i_or_d     = i_or_d_s & run_s;
    assign mem_read   = mem_read_s & run_s;
    assign mem_write  = mem_write_s & run_s;
    assign ir_write   = ir_write_s & run_s;
    assign reg_dst    = reg_dst_s & run_s;
    assign mem_to_reg = mem_to_reg_s & run_s;
    assign reg_write  = reg_write_s & run_s;
    assign alu_src_a  = alu_src_a_s & run_s;
    assign alu_src_b  = alu_src_b_s & {2{run_s}};
    assign alu_op     = alu_op_s & {2{run_s}};
    assign pc_source  = pc_source_s & {2{run_s}};
    assign instr_done = instr_done_s & run_s;
    assign trap       = trap_s & run_s;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: each driven cycle queues the expected control
// vector, and a negedge monitor pops and compares it against the DUT outputs.
module tb_multicycle_control;

    typedef struct packed {
        logic       pc_en;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       instr_done;
        logic       trap;
    } outs_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       pc_en, i_or_d, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a;
    logic [1:0] alu_src_b, alu_op, pc_source;
    logic       instr_done, trap;
    outs_t      got_s;

    int    n_tests = 0;
    int    n_fail  = 0;
    outs_t exp_q[$];
    string tag_q[$];

    multicycle_control #(.WAIT_LIMIT(15)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .pc_en(pc_en), .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write),
        .ir_write(ir_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_source(pc_source),
        .instr_done(instr_done), .trap(trap)
    );

    always #5 clk = ~clk;

    assign got_s = {pc_en, i_or_d, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
                    reg_write, alu_src_a, alu_src_b, alu_op, pc_source, instr_done, trap};

    task automatic check_eq(input string tag, input outs_t got, input outs_t exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %05h expected %05h", tag, got, exp);
        end
    endtask

    // Expected control vectors, one per state, taken from the state table
    function automatic outs_t o_idle();
        outs_t o = '0;
        return o;
    endfunction
    function automatic outs_t o_fetch(input logic rdy);
        outs_t o = '0;
        o.mem_read = 1'b1; o.alu_src_b = 2'b01; o.ir_write = rdy; o.pc_en = rdy;
        return o;
    endfunction
    function automatic outs_t o_decode();
        outs_t o = '0;
        o.alu_src_b = 2'b11;
        return o;
    endfunction
    function automatic outs_t o_addr();
        outs_t o = '0;
        o.alu_src_a = 1'b1; o.alu_src_b = 2'b10;
        return o;
    endfunction
    function automatic outs_t o_memrd();
        outs_t o = '0;
        o.mem_read = 1'b1; o.i_or_d = 1'b1;
        return o;
    endfunction
    function automatic outs_t o_memwb();
        outs_t o = '0;
        o.reg_write = 1'b1; o.mem_to_reg = 1'b1; o.instr_done = 1'b1;
        return o;
    endfunction
    function automatic outs_t o_memwr(input logic rdy);
        outs_t o = '0;
        o.mem_write = 1'b1; o.i_or_d = 1'b1; o.instr_done = rdy;
        return o;
    endfunction
    function automatic outs_t o_exec();
        outs_t o = '0;
        o.alu_src_a = 1'b1; o.alu_op = 2'b10;
        return o;
    endfunction
    function automatic outs_t o_aluwb();
        outs_t o = '0;
        o.reg_write = 1'b1; o.reg_dst = 1'b1; o.instr_done = 1'b1;
        return o;
    endfunction
    function automatic outs_t o_branch(input logic take);
        outs_t o = '0;
        o.alu_src_a = 1'b1; o.alu_op = 2'b01; o.pc_source = 2'b01; o.pc_en = take; o.instr_done = 1'b1;
        return o;
    endfunction
    function automatic outs_t o_jump();
        outs_t o = '0;
        o.pc_source = 2'b10; o.pc_en = 1'b1; o.instr_done = 1'b1;
        return o;
    endfunction
    function automatic outs_t o_addiwb();
        outs_t o = '0;
        o.reg_write = 1'b1; o.instr_done = 1'b1;
        return o;
    endfunction
    function automatic outs_t o_trap();
        outs_t o = '0;
        o.trap = 1'b1;
        return o;
    endfunction

    // Drive one cycle of inputs and queue the outputs expected during it
    task automatic cyc(input string tag, input logic rst, input logic rdy, input logic z, input outs_t e);
        reset = rst; mem_ready = rdy; zero = z;
        exp_q.push_back(e);
        tag_q.push_back(tag);
        @(posedge clk); #1;
    endtask

    // Scoreboard monitor: compare mid-cycle, away from the active edge
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            check_eq(tag_q.pop_front(), got_s, exp_q.pop_front());
        end
    end

    initial begin
        reset = 1'b1; mem_ready = 1'b1; zero = 1'b0; opcode = 6'b000000;
        @(posedge clk); #1;
        cyc("rst0", 1'b1, 1'b1, 1'b0, o_idle());
        cyc("rst1", 1'b1, 1'b1, 1'b0, o_idle());

        // R-type: instr_done in the 4th cycle
        opcode = 6'b000000;
        cyc("r_fetch",  1'b0, 1'b1, 1'b0, o_fetch(1'b1));
        cyc("r_decode", 1'b0, 1'b1, 1'b0, o_decode());
        cyc("r_exec",   1'b0, 1'b1, 1'b0, o_exec());
        cyc("r_wb",     1'b0, 1'b1, 1'b0, o_aluwb());

        // lw with two stall cycles in MEM_RD
        opcode = 6'b100011;
        cyc("lw_fetch",  1'b0, 1'b1, 1'b0, o_fetch(1'b1));
        cyc("lw_decode", 1'b0, 1'b1, 1'b0, o_decode());
        cyc("lw_addr",   1'b0, 1'b1, 1'b0, o_addr());
        cyc("lw_rd_w0",  1'b0, 1'b0, 1'b0, o_memrd());
        cyc("lw_rd_w1",  1'b0, 1'b0, 1'b0, o_memrd());
        cyc("lw_rd_ok",  1'b0, 1'b1, 1'b0, o_memrd());
        cyc("lw_wb",     1'b0, 1'b1, 1'b0, o_memwb());

        // sw with one stall in MEM_WR
        opcode = 6'b101011;
        cyc("sw_fetch",  1'b0, 1'b1, 1'b0, o_fetch(1'b1));
        cyc("sw_decode", 1'b0, 1'b1, 1'b0, o_decode());
        cyc("sw_addr",   1'b0, 1'b1, 1'b0, o_addr());
        cyc("sw_wr_w0",  1'b0, 1'b0, 1'b0, o_memwr(1'b0));
        cyc("sw_wr_ok",  1'b0, 1'b1, 1'b0, o_memwr(1'b1));

        // Branches over both zero values, then jump and addi
        for (int k = 0; k < 4; k++) begin
            opcode = (k < 2) ? 6'b000100 : 6'b000101;
            cyc("br_fetch",  1'b0, 1'b1, 1'b0, o_fetch(1'b1));
            cyc("br_decode", 1'b0, 1'b1, 1'b0, o_decode());
            cyc((k < 2) ? "beq_exec" : "bne_exec", 1'b0, 1'b1, k[0],
                o_branch((k < 2) ? k[0] : ~k[0]));
        end
        opcode = 6'b000010;
        cyc("j_fetch",  1'b0, 1'b1, 1'b0, o_fetch(1'b1));
        cyc("j_decode", 1'b0, 1'b1, 1'b0, o_decode());
        cyc("j_jump",   1'b0, 1'b1, 1'b0, o_jump());
        opcode = 6'b001000;
        cyc("addi_fetch",  1'b0, 1'b1, 1'b0, o_fetch(1'b1));
        cyc("addi_decode", 1'b0, 1'b1, 1'b0, o_decode());
        cyc("addi_ex",     1'b0, 1'b1, 1'b0, o_addr());
        cyc("addi_wb",     1'b0, 1'b1, 1'b0, o_addiwb());

        // Ten stalls in FETCH must not shorten the next fetch's timeout
        opcode = 6'b000000;
        for (int i = 0; i < 10; i++) cyc("fetch_wait10", 1'b0, 1'b0, 1'b0, o_fetch(1'b0));
        cyc("fetch_ok",  1'b0, 1'b1, 1'b0, o_fetch(1'b1));
        cyc("r2_decode", 1'b0, 1'b1, 1'b0, o_decode());
        cyc("r2_exec",   1'b0, 1'b1, 1'b0, o_exec());
        cyc("r2_wb",     1'b0, 1'b1, 1'b0, o_aluwb());

        // Fetch timeout: 16 stalled cycles in FETCH, then TRAP
        for (int i = 0; i < 16; i++) cyc("fetch_stall", 1'b0, 1'b0, 1'b0, o_fetch(1'b0));
        for (int i = 0; i < 3; i++) cyc("timeout_trap", 1'b0, 1'($urandom_range(0, 1)), 1'b0, o_trap());
        cyc("trap_rst", 1'b1, 1'b1, 1'b0, o_idle());

        // Illegal opcode: TRAP is absorbing for 20 cycles, cleared by reset
        opcode = 6'b111111;
        cyc("ill_fetch",  1'b0, 1'b1, 1'b0, o_fetch(1'b1));
        cyc("ill_decode", 1'b0, 1'b1, 1'b0, o_decode());
        for (int i = 0; i < 20; i++) cyc("ill_trap", 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), o_trap());
        cyc("ill_rst", 1'b1, 1'b1, 1'b0, o_idle());
        cyc("post_trap_fetch", 1'b0, 1'b0, 1'b0, o_fetch(1'b0));
        cyc("post_trap_fetch_ok", 1'b0, 1'b1, 1'b0, o_fetch(1'b1));

        // Reset during a stalled store aborts it
        opcode = 6'b101011;
        cyc("sw2_decode", 1'b0, 1'b1, 1'b0, o_decode());
        cyc("sw2_addr",   1'b0, 1'b1, 1'b0, o_addr());
        cyc("sw2_wr_w0",  1'b0, 1'b0, 1'b0, o_memwr(1'b0));
        cyc("sw2_rst",    1'b1, 1'b1, 1'b0, o_idle());
        cyc("sw2_refetch", 1'b0, 1'b1, 1'b0, o_fetch(1'b1));

        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
